multicycle_control: RTL and testbench

- Control FSM for the multicycle RV32 subset datapath (add, sub, xor, addi, xori, lw, sw, beq, jal).
- Sits directly upstream of the ALU and drives its 2-bit ALUControl (00 add, 01 sub, 10 xor, 11 unused).
- Consumes the ALU Zero flag for branches.
- Sequences the shared PC/IR/register/memory datapath through a Moore state machine, one instruction at a time.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/alu_decoder.sv | 22 ++
 rtl/multicycle_control.sv | 120 ++++++++++++
 tb/tb_multicycle_control.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle RV32 control FSM and its ALU decoder
package ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;
  localparam state_t RESET_STATE = S_FETCH;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp/funct fields to ALUControl and flags unsupported funct combinations
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [6:0] opcode,
  output logic [1:0] alu_control,
  output logic       legal
);
  logic w_rtype, w_add, w_sub, w_xor;
  // Instr[30] is an immediate bit for I-type, so it only selects sub for R-type
  assign w_rtype = opcode == OP_R;
  assign w_add = funct3 == 3'b000 && !(w_rtype && funct7b5);
  assign w_sub = funct3 == 3'b000 && w_rtype && funct7b5;
  assign w_xor = funct3 == 3'b100 && !(w_rtype && funct7b5);
  assign legal = w_add | w_sub | w_xor;
  assign alu_control = alu_op == ALUOP_ADD ? ALU_ADD :
                       alu_op == ALUOP_SUB ? ALU_SUB :
                       w_sub ? ALU_SUB : w_xor ? ALU_XOR : ALU_ADD;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM sequencing the shared multicycle RV32 datapath
module multicycle_control
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl,
  output logic       Illegal
);
  state_t r_state, w_next;
  logic [1:0] w_alu_op;
  logic w_legal, w_pc_write, w_ir_write, w_reg_write, w_mem_write;
  alu_decoder u_alu_decoder (
    .alu_op     (w_alu_op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .opcode     (opcode),
    .alu_control(ALUControl),
    .legal      (w_legal)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= RESET_STATE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_pc_write = 1'b0;
    w_ir_write = 1'b0;
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    AdrSrc = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA = SRCA_PC;
    ALUSrcB = SRCB_REG;
    w_alu_op = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        w_next = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                 opcode == OP_R ? (w_legal ? S_EXECUTER : S_ILLEGAL) :
                 opcode == OP_I ? (w_legal ? S_EXECUTEI : S_ILLEGAL) :
                 opcode == OP_BEQ ? S_BEQ : opcode == OP_JAL ? S_JAL : S_ILLEGAL;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        w_next = opcode == OP_SW ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        w_reg_write = 1'b1;
        w_next = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        w_mem_write = 1'b1;
        w_next = S_FETCH;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_REG;
        w_alu_op = ALUOP_FUNCT;
        w_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_REG;
        w_alu_op = ALUOP_SUB;
        w_pc_write = Zero;
        w_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        w_pc_write = 1'b1;
        w_next = S_ALUWB;
      end
      default: w_next = S_ILLEGAL;
    endcase
  end
  // the state already reads FETCH under reset; only the enables need masking
  assign PCWrite = w_pc_write & ~reset;
  assign IRWrite = w_ir_write & ~reset;
  assign RegWrite = w_reg_write & ~reset;
  assign MemWrite = w_mem_write & ~reset;
  assign Illegal = (r_state == S_ILLEGAL) & ~reset;
  assign ImmSrc = imm_sel(opcode);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed scoreboard bench for the multicycle control FSM
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic funct7b5 = 1'b0;
  logic Zero = 1'b0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl;
  logic [15:0] q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .Zero(Zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .Illegal(Illegal)
  );
  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Illegal}
  function automatic logic [15:0] v(input logic pcw, input logic adr, input logic mw, input logic irw,
                                    input logic rw, input logic [1:0] res, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [1:0] imm, input logic [1:0] alu,
                                    input logic ill);
    return {pcw, adr, mw, irw, rw, res, sa, sb, imm, alu, ill};
  endfunction
  function automatic logic [15:0] f_fetch(input logic [1:0] imm);
    return v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, imm, 2'b00, 1'b0);
  endfunction
  function automatic logic [15:0] f_decode(input logic [1:0] imm);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 2'b00, 1'b0);
  endfunction
  function automatic logic [15:0] f_reset(input logic [1:0] imm);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, imm, 2'b00, 1'b0);
  endfunction
  function automatic logic [15:0] f_aluwb(input logic [1:0] imm);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, imm, 2'b00, 1'b0);
  endfunction
  function automatic logic [15:0] f_illegal(input logic [1:0] imm);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, imm, 2'b00, 1'b1);
  endfunction
  task automatic run(input string tag, input int n);
    logic [15:0] obs, e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s cyc%0d scoreboard empty obs=%h", tag, i + 1, obs);
      end else begin
        e = q.pop_front();
        assert (obs === e) else begin
          errors++;
          $error("FAIL %s cyc%0d observed=%h expected=%h", tag, i + 1, obs, e);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic r_type(input string tag, input logic [2:0] f3, input logic f7, input logic [1:0] alu);
    opcode = 7'b0110011; funct3 = f3; funct7b5 = f7; Zero = 1'b1;
    q.push_back(f_fetch(2'b00));
    q.push_back(f_decode(2'b00));
    q.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 1'b0));
    q.push_back(f_aluwb(2'b00));
    run(tag, 4);
  endtask
  task automatic i_type(input string tag, input logic [2:0] f3, input logic f7, input logic [1:0] alu);
    opcode = 7'b0010011; funct3 = f3; funct7b5 = f7; Zero = 1'b1;
    q.push_back(f_fetch(2'b00));
    q.push_back(f_decode(2'b00));
    q.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 1'b0));
    q.push_back(f_aluwb(2'b00));
    run(tag, 4);
  endtask
  task automatic beq(input string tag, input logic z);
    opcode = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = z;
    q.push_back(f_fetch(2'b10));
    q.push_back(f_decode(2'b10));
    q.push_back(v(z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0));
    run(tag, 3);
  endtask
  initial begin
    repeat (3) q.push_back(f_reset(2'b00));
    run("reset", 3);
    reset = 1'b0; opcode = 7'b0000011;
    q.push_back(f_fetch(2'b00));
    q.push_back(f_decode(2'b00));
    q.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0));
    q.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    q.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    run("lw", 5);
    opcode = 7'b0100011; Zero = 1'b1;
    q.push_back(f_fetch(2'b01));
    q.push_back(f_decode(2'b01));
    q.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 1'b0));
    q.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
    run("sw", 4);
    beq("beq_taken", 1'b1);
    beq("beq_not_taken", 1'b0);
    r_type("add", 3'b000, 1'b0, 2'b00);
    r_type("sub", 3'b000, 1'b1, 2'b01);
    r_type("xor", 3'b100, 1'b0, 2'b10);
    i_type("addi", 3'b000, 1'b1, 2'b00);
    i_type("xori", 3'b100, 1'b1, 2'b10);
    opcode = 7'b1101111; Zero = 1'b0;
    q.push_back(f_fetch(2'b11));
    q.push_back(f_decode(2'b11));
    q.push_back(v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 1'b0));
    q.push_back(f_aluwb(2'b11));
    run("jal", 4);
    opcode = 7'b0000011;
    q.push_back(f_fetch(2'b00));
    q.push_back(f_decode(2'b00));
    q.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0));
    q.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    run("lw_abort", 4);
    reset = 1'b1;
    q.push_back(f_reset(2'b00));
    run("abort_reset", 1);
    reset = 1'b0; opcode = 7'b0110011; funct3 = 3'b111; funct7b5 = 1'b0;
    q.push_back(f_fetch(2'b00));
    q.push_back(f_decode(2'b00));
    repeat (10) q.push_back(f_illegal(2'b00));
    run("illegal_funct", 12);
    reset = 1'b1;
    q.push_back(f_reset(2'b00));
    run("illegal_reset", 1);
    reset = 1'b0; opcode = 7'b0000000; funct3 = 3'b000;
    q.push_back(f_fetch(2'b00));
    q.push_back(f_decode(2'b00));
    q.push_back(f_illegal(2'b00));
    q.push_back(f_illegal(2'b00));
    run("illegal_opcode", 4);
    reset = 1'b1;
    q.push_back(f_reset(2'b00));
    run("opcode_reset", 1);
    reset = 1'b0; opcode = 7'b0100011;
    q.push_back(f_fetch(2'b01));
    run("refetch", 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
